clock_div_prog: RTL and testbench

Programmable, run-time reloadable clock divider; parametrised successor to the fixed 1 MHz to 10 Hz divider. It derives a divided clock-enable waveform (CLK_OUT) and an optional one-cycle period-start strobe (TICK_OUT) from the 1 MHz system clock. The divide ratio is loaded through a handshake and applied glitch-free at a period boundary. A SYNC input re-phases the output to an external event, such as a GPS PPS already synchronised to CLK_1MHZ_IN. The block feeds sampling and telemetry schedulers.

---
 rtl/clock_div_prog.sv | 95 +++++++++
 tb/tb_clock_div_prog.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_prog.sv
// Programmable divider producing a registered divided clock and period-start strobe.
// Define CLKDIV_TICK_EN to build the TICK_OUT strobe register; otherwise TICK_OUT is tied low.
module clock_div_prog #(
    parameter int WIDTH       = 17,
    parameter int DEFAULT_DIV = 100000
) (
    input  logic             CLK_1MHZ_IN,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             SYNC,
    input  logic [WIDTH-1:0] DIV_IN,
    input  logic             DIV_LOAD,
    output logic             DIV_BUSY,
    output logic             DIV_ERR,
    output logic             CLK_OUT,
    output logic             TICK_OUT
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] div_n;
    logic [WIDTH-1:0] pend;
    logic             busy;
    logic             err;
    logic             clk_q;
    logic [WIDTH:0]   half;
    logic             boundary;
    logic             restart;

    // One extra bit so N+1 cannot wrap for N = 2^WIDTH-1.
    assign half     = ({1'b0, div_n} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    assign boundary = ENABLE && (count == div_n);
    assign restart  = SYNC || boundary;

    always_ff @(posedge CLK_1MHZ_IN) begin
        if (!RESET) begin
            count <= ONE;
            clk_q <= 1'b1;
            div_n <= DEF_DIV;
            pend  <= DEF_DIV;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;

            if (restart) begin
                count <= ONE;
                clk_q <= 1'b1;
            end else if (ENABLE) begin
                count <= count + ONE;
                if ({1'b0, count} == half)
                    clk_q <= 1'b0;
            end

            if (restart && busy) begin
                div_n <= pend;
                busy  <= 1'b0;
            end

            // Busy here is the value before this edge, so a load landing on the
            // applying edge is rejected and a fresh accept waits for the next restart.
            if (DIV_LOAD) begin
                if (busy || (DIV_IN < MIN_DIV)) begin
                    err <= 1'b1;
                end else begin
                    pend <= DIV_IN;
                    busy <= 1'b1;
                end
            end
        end
    end

`ifdef CLKDIV_TICK_EN
    logic tick_q;

    always_ff @(posedge CLK_1MHZ_IN) begin
        if (!RESET)
            tick_q <= 1'b0;
        else
            tick_q <= restart;
    end

    assign TICK_OUT = tick_q;
`else
    assign TICK_OUT = 1'b0;
`endif

    assign CLK_OUT  = clk_q;
    assign DIV_BUSY = busy;
    assign DIV_ERR  = err;

endmodule

// File: tb/tb_clock_div_prog.sv
// Directed bench for clock_div_prog: period shape, load handshake, SYNC, ENABLE hold, reset.
module tb_clock_div_prog;

    localparam int WIDTH = 17;
    localparam int DEF   = 1000;
    localparam int LIMIT = 5000;
`ifdef CLKDIV_TICK_EN
    localparam int TICK_ON = 1;
`else
    localparam int TICK_ON = 0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             sync;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             div_busy;
    logic             div_err;
    logic             clk_out;
    logic             tick_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clock_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
        .CLK_1MHZ_IN (clk),
        .RESET       (reset),
        .ENABLE      (enable),
        .SYNC        (sync),
        .DIV_IN      (div_in),
        .DIV_LOAD    (div_load),
        .DIV_BUSY    (div_busy),
        .DIV_ERR     (div_err),
        .CLK_OUT     (clk_out),
        .TICK_OUT    (tick_out)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Counts one period from the current (high) observation to the next period start.
    task automatic measure(input string tag, input int exp_hi, input int exp_lo, input int exp_tk);
        int hi = 0;
        int lo = 0;
        int tk = 0;
        while (clk_out === 1'b1 && hi < LIMIT) begin
            hi++;
            tk += int'(tick_out);
            step();
        end
        while (clk_out === 1'b0 && lo < LIMIT) begin
            lo++;
            tk += int'(tick_out);
            step();
        end
        check_val({tag, "_hi"}, hi, exp_hi);
        check_val({tag, "_lo"}, lo, exp_lo);
        check_val({tag, "_tick"}, tk, TICK_ON * exp_tk);
    endtask

    task automatic wait_period_start(input string tag);
        int n = 0;
        while (clk_out === 1'b1 && n < LIMIT) begin
            step();
            n++;
        end
        while (clk_out === 1'b0 && n < LIMIT) begin
            step();
            n++;
        end
        check_val({tag, "_in_time"}, int'(n < LIMIT), 1);
    endtask

    task automatic load(input int val);
        div_in   = WIDTH'(val);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    initial begin
        int bad;
        int lo;
        reset    = 1'b0;
        enable   = 1'b1;
        sync     = 1'b0;
        div_in   = '0;
        div_load = 1'b0;
        step_n(3);
        check_val("rst_clk", int'(clk_out), 1);
        check_val("rst_tick", int'(tick_out), 0);
        check_val("rst_busy", int'(div_busy), 0);
        check_val("rst_err", int'(div_err), 0);

        // Default ratio: first period has no strobe, later ones do.
        reset = 1'b1;
        measure("def_p1", 500, 500, 0);
        measure("def_p2", 500, 500, 1);

        // Load 5 mid-period; applied at the next boundary.
        step_n(100);
        load(5);
        check_val("ld5_busy", int'(div_busy), 1);
        step_n(50);
        check_val("ld5_busy_hold", int'(div_busy), 1);
        wait_period_start("ld5_wait");
        check_val("ld5_busy_clr", int'(div_busy), 0);
        check_val("ld5_tick", int'(tick_out), TICK_ON);
        measure("n5_p1", 3, 2, 1);
        measure("n5_p2", 3, 2, 1);

        // Load 7 then 9 while busy: second rejected, 7 applied.
        load(7);
        check_val("ld7_busy", int'(div_busy), 1);
        check_val("ld7_err", int'(div_err), 0);
        load(9);
        check_val("ld9_err", int'(div_err), 1);
        check_val("ld9_busy", int'(div_busy), 1);
        step();
        check_val("ld9_err_clr", int'(div_err), 0);
        wait_period_start("ld7_wait");
        check_val("ld7_busy_clr", int'(div_busy), 0);
        measure("n7_p1", 4, 3, 1);

        // Ratio below 2 is rejected without going busy.
        load(1);
        check_val("ld1_err", int'(div_err), 1);
        check_val("ld1_busy", int'(div_busy), 0);
        step();
        check_val("ld1_err_clr", int'(div_err), 0);

        // Ratio 10, SYNC at counter 7.
        load(10);
        wait_period_start("ld10_wait");
        measure("n10_p1", 5, 5, 1);
        step_n(6);
        check_val("pre_sync_clk", int'(clk_out), 0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_val("sync_clk", int'(clk_out), 1);
        check_val("sync_tick", int'(tick_out), TICK_ON);
        measure("sync_p1", 5, 5, 1);

        // SYNC with a load pending applies the new ratio at once.
        load(4);
        check_val("ld4_busy", int'(div_busy), 1);
        step_n(4);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_val("sync4_clk", int'(clk_out), 1);
        check_val("sync4_tick", int'(tick_out), TICK_ON);
        check_val("sync4_busy", int'(div_busy), 0);
        measure("n4_p1", 2, 2, 1);

        // ENABLE low in the low phase holds everything.
        load(10);
        wait_period_start("en_wait");
        step_n(6);
        enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (clk_out !== 1'b0 || tick_out !== 1'b0) bad++;
        end
        check_val("hold_low", bad, 0);
        enable = 1'b1;
        lo = 0;
        while (clk_out === 1'b0 && lo < LIMIT) begin
            lo++;
            step();
        end
        check_val("resume_lo", lo, 4);
        check_val("resume_tick", int'(tick_out), TICK_ON);

        // SYNC while disabled still restarts the period.
        step_n(6);
        enable = 1'b0;
        step_n(3);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_val("dis_sync_clk", int'(clk_out), 1);
        check_val("dis_sync_tick", int'(tick_out), TICK_ON);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (clk_out !== 1'b1 || tick_out !== 1'b0) bad++;
        end
        check_val("dis_sync_hold", bad, 0);
        enable = 1'b1;
        measure("dis_sync_p1", 5, 5, 0);

        // Reset mid-period with a load pending restores the default ratio.
        reset = 1'b0;
        step();
        reset = 1'b1;
        step_n(299);
        load(7);
        check_val("prerst_busy", int'(div_busy), 1);
        reset = 1'b0;
        step_n(2);
        check_val("rst2_clk", int'(clk_out), 1);
        check_val("rst2_tick", int'(tick_out), 0);
        check_val("rst2_busy", int'(div_busy), 0);
        check_val("rst2_err", int'(div_err), 0);
        reset = 1'b1;
        measure("rst2_p1", 500, 500, 0);
        measure("rst2_p2", 500, 500, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
